// File: rtl/vga_sync_decoder.sv
// VGA receive-side timing decoder: locks to hsync/vsync geometry, recovers pixel coordinates.
// Optional VGA_DEC_MEASURE_EN builds the h_meas/v_meas measurement registers.
module vga_sync_decoder #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_START = 144,
  parameter int unsigned H_VALID = 640,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_START = 35,
  parameter int unsigned V_VALID = 480,
  parameter int unsigned V_TOTAL = 525
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [15:0] rgb_in,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_valid,
  output logic [15:0] rgb_out,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_cnt,
  output logic [10:0] h_meas,
  output logic [10:0] v_meas
);

  localparam logic [10:0] CntMax = 11'h7FF;
  localparam logic [10:0] HLast  = 11'(H_TOTAL - 1);
  localparam logic [10:0] VLast  = 11'(V_TOTAL - 1);
  localparam logic [10:0] HBeg   = 11'(H_START);
  localparam logic [10:0] HEnd   = 11'(H_START + H_VALID);
  localparam logic [10:0] VBeg   = 11'(V_START);
  localparam logic [10:0] VEnd   = 11'(V_START + V_VALID);

  // The active window must sit after the sync pulse and inside the line/frame.
  if (H_START < H_SYNC || H_START + H_VALID > H_TOTAL || V_START + V_VALID > V_TOTAL)
  begin : g_bad_geometry
    $error("vga_sync_decoder: inconsistent timing geometry");
  end

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  state_e      state_q, state_d;
  logic        hs_d, vs_d;
  logic        hs_rise, vs_rise, err;
  logic [10:0] h_cnt_q, v_cnt_q, h_inc, v_inc, h_cur, v_cur;

  logic [9:0]  pix_x_d, pix_y_d;
  logic        pix_valid_d, frame_start_d, locked_d, in_win;
  logic [15:0] rgb_out_d;
  logic [7:0]  err_cnt_d;

  assign hs_rise = hsync_in & ~hs_d;
  assign vs_rise = vsync_in & ~vs_d;

  // Counters hold the index of the previous sample; h_cur/v_cur index the current one.
  assign h_inc = (h_cnt_q == CntMax) ? CntMax : h_cnt_q + 11'd1;
  assign v_inc = (v_cnt_q == CntMax) ? CntMax : v_cnt_q + 11'd1;

  always_comb begin
    h_cur = hs_rise ? 11'd0 : h_inc;
    v_cur = v_cnt_q;
    if (hs_rise) v_cur = vs_rise ? 11'd0 : v_inc;
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hs_d    <= 1'b0;
      vs_d    <= 1'b0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      hs_d    <= hsync_in;
      vs_d    <= vsync_in;
      h_cnt_q <= h_cur;
      v_cnt_q <= v_cur;
    end
  end

  // State register
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= StSearch;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    err     = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (vs_rise) state_d = StMeasure;
      end
      StMeasure: begin
        if (vs_rise && h_cnt_q == HLast && v_cnt_q == VLast) state_d = StLocked;
      end
      StLocked: begin
        err = (hs_rise && h_cnt_q != HLast) || (!hs_rise && h_cnt_q == HLast) ||
              (vs_rise && v_cnt_q != VLast);
        if (err) state_d = StSearch;
      end
      default: state_d = StSearch;
    endcase
  end

  // Output logic; gating on state_d blanks the erroring sample itself.
  always_comb begin
    locked_d      = (state_d == StLocked);
    in_win        = locked_d && (h_cur >= HBeg) && (h_cur < HEnd) &&
                    (v_cur >= VBeg) && (v_cur < VEnd);
    pix_x_d       = in_win ? 10'(h_cur - HBeg) : 10'h3FF;
    pix_y_d       = in_win ? 10'(v_cur - VBeg) : 10'h3FF;
    pix_valid_d   = in_win;
    rgb_out_d     = in_win ? rgb_in : 16'h0000;
    frame_start_d = in_win && (h_cur == HBeg) && (v_cur == VBeg);
    err_cnt_d     = err_cnt;
    if (err && err_cnt != 8'hFF) err_cnt_d = err_cnt + 8'd1;
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pix_x       <= 10'h3FF;
      pix_y       <= 10'h3FF;
      pix_valid   <= 1'b0;
      rgb_out     <= 16'h0000;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_cnt     <= 8'h00;
    end else begin
      pix_x       <= pix_x_d;
      pix_y       <= pix_y_d;
      pix_valid   <= pix_valid_d;
      rgb_out     <= rgb_out_d;
      frame_start <= frame_start_d;
      locked      <= locked_d;
      err_cnt     <= err_cnt_d;
    end
  end

`ifdef VGA_DEC_MEASURE_EN
  logic [10:0] h_meas_q, v_meas_q;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_meas_q <= '0;
      v_meas_q <= '0;
    end else begin
      if (hs_rise) h_meas_q <= h_inc;
      if (vs_rise) v_meas_q <= v_inc;
    end
  end

  assign h_meas = h_meas_q;
  assign v_meas = v_meas_q;
`else
  assign h_meas = '0;
  assign v_meas = '0;
`endif

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

- Receive-side counterpart of the VGA sync generator.
- Consumes a VGA-style stream (hsync, vsync, 16-bit RGB565) on the pixel clock.
- Measures line and frame timing, locks when the timing matches the configured 640x480@60 geometry, then recovers pixel coordinates and gates active-area pixel data.
- Sits at the capture/loopback end of the display path, and is used to self-check generated video and to feed downstream frame logic.

## Interface

Parameters:

- H_SYNC, 96: hsync pulse width in clocks.
- H_START, 144: first active column index (sync + back porch + left border).
- H_VALID, 640: active columns.
- H_TOTAL, 800: clocks per line.
- V_START, 35: first active line index.
- V_VALID, 480: active lines.
- V_TOTAL, 525: lines per frame.

Ports:

- vga_clk, in, 1: pixel clock.
- sys_rst, in, 1: reset, asynchronous, active-high.
- hsync_in, in, 1: horizontal sync, active-high pulse.
- vsync_in, in, 1: vertical sync, active-high pulse.
- rgb_in, in, 16: pixel data.
- pix_x, out, 10: active column 0..639, 10'h3FF when not valid.
- pix_y, out, 10: active row 0..479, 10'h3FF when not valid.
- pix_valid, out, 1: active-area pixel on rgb_out.
- rgb_out, out, 16: rgb_in when pix_valid, else 0.
- frame_start, out, 1: one-cycle pulse at pix_x=0, pix_y=0.
- locked, out, 1: timing lock.
- err_cnt, out, 8: saturating count of timing errors detected while locked.
- h_meas, out, 11: measured clocks per line (see Configuration).
- v_meas, out, 11: measured lines per frame (see Configuration).

## Operation

**Edge detection**
- Inputs are registered once (hs_d, vs_d).
- An hsync rise is hsync_in=1 with hs_d=0; a vsync rise is defined the same way.
- The sample carrying an hsync rise has horizontal index h=0. A vsync rise marks line v=0.

**Counters**
- h_cnt and v_cnt are 11 bits each.
- h_cnt clears on an hsync rise, otherwise increments and saturates at 2047.
- v_cnt clears when an hsync rise and a vsync rise occur on the same sample, increments on every other hsync rise, and saturates at 2047.

**State machine** (SEARCH, MEASURE, LOCKED)
- Reset enters SEARCH.
- SEARCH: the first vsync rise moves to MEASURE.
- MEASURE: at the next vsync rise, compare (last line length == H_TOTAL) and (lines since the previous vsync == V_TOTAL).
  - Both match: go to LOCKED.
  - Otherwise: stay in MEASURE and restart the measurement.
- LOCKED: an error is any of the following:
  - an hsync rise with h_cnt != H_TOTAL-1;
  - h_cnt reaching H_TOTAL-1 with no hsync rise on the following sample;
  - a vsync rise with v_cnt != V_TOTAL-1.
- On error: go to SEARCH, clear locked, and increment err_cnt (saturating at 255).
- When a vsync rise and an hsync error occur on the same sample, it counts once.

**Pixel output**
- Only while LOCKED and H_START <= h < H_START+H_VALID and V_START <= v < V_START+V_VALID:
  - pix_x = h - H_START;
  - pix_y = v - V_START;
  - pix_valid = 1;
  - rgb_out = rgb_in.
- Outside that window: pix_x and pix_y are 3FF, pix_valid = 0, rgb_out = 0.
- Subtractions are 11-bit and truncated to 10 bits, valid only inside the window.

## Timing

- Every output is registered, with 1-cycle latency from the input sample at vga_clk.
- Reset values: pix_x and pix_y = 10'h3FF; pix_valid, rgb_out, frame_start, locked, err_cnt, h_meas and v_meas = 0; state = SEARCH.
- locked rises in the cycle after the second vsync-rise sample (end of the first fully measured frame).
- The first valid pixel is at the output H_START clocks into line V_START of the following frame, plus 1 cycle.
- locked falls in the cycle after the erroring sample.
- pix_valid drops on that same cycle; no partial-frame output follows.
- Reset mid-frame: all state is cleared immediately and asynchronously. After release, lock needs two vsync rises again.

## Configuration

VGA_DEC_MEASURE_EN:
- Defined:
  - h_meas is updated on each hsync rise with h_cnt+1 (the saturated value if the line is too long).
  - v_meas is updated on each vsync rise with v_cnt+1.
- Undefined:
  - the measurement registers are not built;
  - h_meas and v_meas are tied to 0;
  - the lock comparison uses only the internal counters.

## Test plan

1. Reset asserted mid-stream: all outputs hold their reset values while sys_rst=1, and locked=0 for the first frame after release.
2. Nominal 800x525 stimulus:
   - locked=1 one cycle after the second vsync rise;
   - sample h=144,v=35 with rgb_in=16'hF800 gives pix_x=0, pix_y=0, pix_valid=1, rgb_out=F800 and frame_start=1 one cycle later;
   - h=783,v=514 gives pix_x=639, pix_y=479;
   - h=784 gives pix_valid=0, pix_x=3FF, rgb_out=0.
3. While locked, inject an hsync rise at h=700: locked=0 next cycle, err_cnt=1, relock after two further good vsync rises.
4. Stimulus with 799-clock lines: locked never asserts over 4 frames, err_cnt stays 0, and h_meas=799 (with macro).
5. While locked, suppress one hsync pulse: error at h_cnt=H_TOTAL-1 plus 1, err_cnt increments. After 300 forced errors, err_cnt=255.
6. While locked, move the vsync rise to line 524: error detected, locked=0, v_meas=524 (with macro).
